issue_queue: RTL
================

# issue_queue

Parametrised instruction buffer and dual-issue selector between the fetch stage (`pc`/`imem` pair) and the register-read stage. Accepts two fetched words per cycle into a circular buffer of `DEPTH` entries, each tagged with its word PC, and issues one or two instructions per cycle to the two ALU lanes. Issue is gated by structural and data-hazard rules. Provides fetch backpressure, a jump flush and a downstream stall.

## Interface
- `DEPTH`, 8: buffer entries; power of two, ≥4.
- `DW`, 32: instruction and PC width.
- `clk` in 1: clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `flush` in 1: taken jump/branch from an ALU lane (`jmp`); discards all buffered and incoming words.
- `stall` in 1: downstream hold; no pop, issue outputs hold.
- `in_valid` in 1: `in_ins0`/`in_ins1` are valid this cycle.
- `in_ins0`, `in_ins1` in DW: fetched words at PC `in_pc` and `in_pc+1`.
- `in_pc` in DW: word PC of `in_ins0`.
- `in_ready` out 1: buffer has ≥2 free entries; fetch may advance.
- `out_valid0` out 1: slot 0 carries an instruction.
- `out_en1` out 1: slot 1 carries an instruction (ALU2 enable).
- `out_ins0`, `out_ins1` out DW: issued words; 0 (NOP) when the slot is invalid.
- `out_pc` out DW: PC of `out_ins0`; slot 1 PC is implicitly `out_pc+1`.
- `count` out clog2(DEPTH)+1: occupied entries.

## Operation
- Storage: `DEPTH` × {ins, pc}. Read pointer `rp` and write pointer `wp` are clog2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked separately, so full (count==DEPTH) and empty (count==0) are unambiguous.
- Push: when `in_valid && in_ready && !flush`, write {in_ins0,in_pc} at wp and {in_ins1,in_pc+1} at wp+1; wp += 2.
- `in_ready` = (DEPTH − count) ≥ 2. It is derived combinationally from registered `count`.
- Instruction classes, by opcode [31:26] and funct [5:0]:
  - control = jr (op 0, funct 001000), jal (000011), beq (000100).
  - mem = lw (100011), sw (101011).
- dest(i): R-type non-jr → [15:11]; addi/lw → [20:16]; jal → 31; otherwise 0.
- srcs(i):
  - R-type, beq, sw → [25:21] and [20:16].
  - addi, lw, jr → [25:21].
  - jal → none.
- Pair rule: A = entry at rp, B = entry at rp+1. B issues in slot 1 only if all of the following hold:
  - count ≥ 2;
  - A is not control;
  - B is neither control nor mem;
  - dest(A) is 0, or dest(A) ∉ srcs(B) and dest(A) ≠ dest(B).
- Issue, when `!stall && !flush`:
  - count==0 → out_valid0=0, out_en1=0, outs 0, out_pc holds.
  - Otherwise slot 0 = A, out_valid0=1; out_en1 = pair rule; pop 1 or 2 entries.
- count update: count_next = count + push×2 − pop. Push and pop in the same cycle are legal, including at count==DEPTH−2 with a pop of 1 or 2.
- Flush (dominates push and pop): rp=wp=0, count=0. Outputs go to 0/invalid at that edge. The incoming pair that cycle is dropped.
- Stall without flush: all outputs and rp hold. Push still proceeds while `in_ready`.
- Reset: rp=wp=count=0; out_valid0=0, out_en1=0, out_ins0=out_ins1=0, out_pc=0. in_ready=1 after reset.

## Timing
- All outputs are registered except `in_ready`.
- Latency: a word pushed at edge N is issuable at edge N+1, when it is at rp and there is no stall.
- Throughput: up to 2 in, up to 2 out per cycle.
- `flush` in cycle N: buffer empty after edge N. The first refetched pair may be pushed at edge N+1.
- `rst` has priority over `flush`, `stall` and push.

## Configuration
- `ISSUE_QUEUE_DUAL_EN` defined: pair rule applied; `out_en1` may assert.
- Not defined: single-issue. `out_en1` tied 0, `out_ins1`=0, pop ≤1 per cycle. All other behaviour is unchanged.

## Test plan
- Reset, then push add $3,$1,$2 (0x00221820) + add $6,$4,$5 (0x00853020) at pc 0 → next edge out_valid0=1, out_en1=1, out_pc=0, count returns to 0.
- Push add $3,$1,$2 + add $4,$3,$5 (RAW on $3) → slot 0 issues alone, out_en1=0; second word issues next cycle at out_pc=1.
- Push beq then addi, and separately addi then lw → out_en1=0 in both cases; each word issues singly.
- Push every cycle with stall=1, DEPTH=8 → count 2,4,6,8; in_ready falls once count=8; no push accepted after that; outputs held.
- count=6 with flush=1 and in_valid=1 simultaneously → count=0, out_valid0=0 next edge; dropped pair never issued.
- Fill so wp wraps past DEPTH−1 while popping → issue order and out_pc sequence continuous across the wrap; without `ISSUE_QUEUE_DUAL_EN`, out_en1 never asserts.

Source files
------------

// File: rtl/issue_queue_if.sv
// rtl/issue_queue_if.sv - fetch-side push and dual-lane issue bundle for issue_queue
// master drives fetch/control inputs and observes issue outputs; slave is the queue.
interface issue_queue_if #(
  parameter int DW = 32,
  parameter int CW = 4
);
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic [DW-1:0] in_ins0;
  logic [DW-1:0] in_ins1;
  logic [DW-1:0] in_pc;
  logic          in_ready;
  logic          out_valid0;
  logic          out_en1;
  logic [DW-1:0] out_ins0;
  logic [DW-1:0] out_ins1;
  logic [DW-1:0] out_pc;
  logic [CW-1:0] count;

  modport master (
    output flush, stall, in_valid, in_ins0, in_ins1, in_pc,
    input  in_ready, out_valid0, out_en1, out_ins0, out_ins1, out_pc, count
  );

  modport slave (
    input  flush, stall, in_valid, in_ins0, in_ins1, in_pc,
    output in_ready, out_valid0, out_en1, out_ins0, out_ins1, out_pc, count
  );
endinterface

// File: rtl/issue_queue.sv
// rtl/issue_queue.sv - circular instruction buffer with single/dual issue selection
// Define ISSUE_QUEUE_DUAL_EN to enable pairing into lane 1; otherwise single-issue.
module issue_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 32
) (
  input  logic        clk,
  input  logic        rst,
  issue_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] ins_q [DEPTH];
  logic [DW-1:0] ins_d [DEPTH];
  logic [DW-1:0] pc_q  [DEPTH];
  logic [DW-1:0] pc_d  [DEPTH];

  logic [PW-1:0] rp_q, rp_d, wp_q, wp_d, rp1, wp1;
  logic [CW-1:0] count_q, count_d, pop;
  logic          out_valid0_q, out_valid0_d;
  logic          out_en1_q, out_en1_d;
  logic [DW-1:0] out_ins0_q, out_ins0_d;
  logic [DW-1:0] out_ins1_q, out_ins1_d;
  logic [DW-1:0] out_pc_q, out_pc_d;
  logic [DW-1:0] ins_a, ins_b;
  logic          push, issue, pair;

  function automatic logic is_ctrl(input logic [31:0] i);
    return (i[31:26] == 6'd0 && i[5:0] == 6'b001000) ||
           i[31:26] == 6'b000011 || i[31:26] == 6'b000100;
  endfunction

  function automatic logic is_mem(input logic [31:0] i);
    return i[31:26] == 6'b100011 || i[31:26] == 6'b101011;
  endfunction

  function automatic logic [4:0] dest_of(input logic [31:0] i);
    logic [4:0] d;
    d = 5'd0;
    if (i[31:26] == 6'd0 && i[5:0] != 6'b001000) d = i[15:11];
    else if (i[31:26] == 6'b001000 || i[31:26] == 6'b100011) d = i[20:16];
    else if (i[31:26] == 6'b000011) d = 5'd31;
    return d;
  endfunction

  // {rs read, rt read}
  function automatic logic [1:0] src_use(input logic [31:0] i);
    logic [1:0] u;
    u = 2'b00;
    if (i[31:26] == 6'd0) u = (i[5:0] == 6'b001000) ? 2'b10 : 2'b11;
    else if (i[31:26] == 6'b000100 || i[31:26] == 6'b101011) u = 2'b11;
    else if (i[31:26] == 6'b001000 || i[31:26] == 6'b100011) u = 2'b10;
    return u;
  endfunction

  function automatic logic can_pair(input logic [31:0] a, input logic [31:0] b);
    logic [4:0] da;
    logic [1:0] ub;
    logic       hazard;
    da     = dest_of(a);
    ub     = src_use(b);
    hazard = (da != 5'd0) &&
             ((ub[1] && b[25:21] == da) || (ub[0] && b[20:16] == da) ||
              dest_of(b) == da);
    return !is_ctrl(a) && !is_ctrl(b) && !is_mem(b) && !hazard;
  endfunction

  assign bus.in_ready   = (count_q <= CW'(DEPTH - 2));
  assign bus.out_valid0 = out_valid0_q;
  assign bus.out_en1    = out_en1_q;
  assign bus.out_ins0   = out_ins0_q;
  assign bus.out_ins1   = out_ins1_q;
  assign bus.out_pc     = out_pc_q;
  assign bus.count      = count_q;

  always_comb begin
    ins_d        = ins_q;
    pc_d         = pc_q;
    rp_d         = rp_q;
    wp_d         = wp_q;
    out_valid0_d = out_valid0_q;
    out_en1_d    = out_en1_q;
    out_ins0_d   = out_ins0_q;
    out_ins1_d   = out_ins1_q;
    out_pc_d     = out_pc_q;
    rp1          = rp_q + PW'(1);
    wp1          = wp_q + PW'(1);
    ins_a        = ins_q[rp_q];
    ins_b        = ins_q[rp1];
`ifdef ISSUE_QUEUE_DUAL_EN
    pair         = (count_q >= CW'(2)) && can_pair(ins_a[31:0], ins_b[31:0]);
`else
    pair         = 1'b0;
`endif
    push         = bus.in_valid && bus.in_ready && !bus.flush;
    issue        = !bus.stall && !bus.flush && (count_q != '0);
    pop          = issue ? (pair ? CW'(2) : CW'(1)) : '0;

    if (push) begin
      ins_d[wp_q] = bus.in_ins0;
      pc_d[wp_q]  = bus.in_pc;
      ins_d[wp1]  = bus.in_ins1;
      pc_d[wp1]   = bus.in_pc + DW'(1);
      wp_d        = wp_q + PW'(2);
    end

    if (issue) begin
      out_valid0_d = 1'b1;
      out_en1_d    = pair;
      out_ins0_d   = ins_a;
      out_ins1_d   = pair ? ins_b : '0;
      out_pc_d     = pc_q[rp_q];
      rp_d         = pair ? rp_q + PW'(2) : rp1;
    end else if (!bus.stall) begin
      // empty and not held: present NOPs but keep the last PC
      out_valid0_d = 1'b0;
      out_en1_d    = 1'b0;
      out_ins0_d   = '0;
      out_ins1_d   = '0;
    end

    count_d = count_q + (push ? CW'(2) : CW'(0)) - pop;

    if (bus.flush) begin
      rp_d         = '0;
      wp_d         = '0;
      count_d      = '0;
      out_valid0_d = 1'b0;
      out_en1_d    = 1'b0;
      out_ins0_d   = '0;
      out_ins1_d   = '0;
      out_pc_d     = '0;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    ins_q <= ins_d;
    pc_q  <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q         <= '0;
      wp_q         <= '0;
      count_q      <= '0;
      out_valid0_q <= 1'b0;
      out_en1_q    <= 1'b0;
      out_ins0_q   <= '0;
      out_ins1_q   <= '0;
      out_pc_q     <= '0;
    end else begin
      rp_q         <= rp_d;
      wp_q         <= wp_d;
      count_q      <= count_d;
      out_valid0_q <= out_valid0_d;
      out_en1_q    <= out_en1_d;
      out_ins0_q   <= out_ins0_d;
      out_ins1_q   <= out_ins1_d;
      out_pc_q     <= out_pc_d;
    end
  end
endmodule
